light_sequencer: RTL

- Control FSM that sequences the traffic-light datapath: timer (1 Hz prescaler + down counter + green/yellow time mux) and the two light decoders.
- Drives load_enable, time_sel and the NS/EW light commands; consumes timer_zero.
- Adds a synchronised emergency override that brings the junction to all-red as early as safely possible.
- Sits beside the datapath inside the top-level controller; no knowledge of CLK_FREQ.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/sync_ff.sv | 20 ++
 rtl/light_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-light constants: light commands, timer select codes and sequencer state encodings.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 2;
  localparam int unsigned STATE_W = 3;

  typedef logic [LIGHT_W-1:0] light_cmd_t;

  localparam light_cmd_t LIGHT_RED    = 2'b00;
  localparam light_cmd_t LIGHT_YELLOW = 2'b01;
  localparam light_cmd_t LIGHT_GREEN  = 2'b10;

  localparam logic TIME_SEL_GREEN  = 1'b0;
  localparam logic TIME_SEL_YELLOW = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT      = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALL_RED   = 3'd5
  } state_e;

  // True for states whose entry loads the phase counter.
  function automatic logic is_timed_state(input state_e s);
    return (s == ST_NS_GREEN) || (s == ST_NS_YELLOW) ||
           (s == ST_EW_GREEN) || (s == ST_EW_YELLOW);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop level synchroniser for an asynchronous single-bit input.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/light_sequencer.sv
// Traffic-light control FSM: sequences green/yellow phases via the timer load
// handshake and brings the junction to all-red on a synchronised emergency.
module light_sequencer
  import traffic_pkg::*;
#(
  parameter bit          START_EW    = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       timer_zero,
  input  logic       emergency,
  output logic       load_enable,
  output logic       time_sel,
  output logic [1:0] ns_light_cmd,
  output logic [1:0] ew_light_cmd,
  output logic       emergency_active,
  output logic [2:0] state
);

  localparam state_e ST_START = START_EW ? ST_EW_GREEN : ST_NS_GREEN;

  state_e     r_state;
  logic       r_load_enable;
  logic       r_time_sel;
  light_cmd_t r_ns_cmd;
  light_cmd_t r_ew_cmd;
  logic       r_emg_active;

  state_e     w_next_state;
  logic       w_load_enable;
  logic       w_time_sel;
  light_cmd_t w_ns_cmd;
  light_cmd_t w_ew_cmd;
  logic       w_emg_active;
  logic       w_emg_sync;
  logic       w_timer_done;

  sync_ff #(.STAGES(SYNC_STAGES)) u_emg_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (emergency),
    .o_q   (w_emg_sync)
  );

  // The counter still shows its old count during the load cycle.
  assign w_timer_done = timer_zero && !r_load_enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_INIT;
      r_load_enable <= 1'b0;
      r_time_sel    <= TIME_SEL_GREEN;
      r_ns_cmd      <= LIGHT_RED;
      r_ew_cmd      <= LIGHT_RED;
      r_emg_active  <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_load_enable <= w_load_enable;
      r_time_sel    <= w_time_sel;
      r_ns_cmd      <= w_ns_cmd;
      r_ew_cmd      <= w_ew_cmd;
      r_emg_active  <= w_emg_active;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_time_sel    = TIME_SEL_GREEN;
    w_ns_cmd      = LIGHT_RED;
    w_ew_cmd      = LIGHT_RED;
    w_emg_active  = 1'b0;
    w_load_enable = 1'b0;

    // Greens are only reachable when no emergency is pending; yellows always run out.
    unique case (r_state)
      ST_INIT:      w_next_state = w_emg_sync ? ST_ALL_RED : ST_START;
      ST_NS_GREEN:  if (!r_load_enable && (timer_zero || w_emg_sync)) w_next_state = ST_NS_YELLOW;
      ST_NS_YELLOW: if (w_timer_done) w_next_state = w_emg_sync ? ST_ALL_RED : ST_EW_GREEN;
      ST_EW_GREEN:  if (!r_load_enable && (timer_zero || w_emg_sync)) w_next_state = ST_EW_YELLOW;
      ST_EW_YELLOW: if (w_timer_done) w_next_state = w_emg_sync ? ST_ALL_RED : ST_NS_GREEN;
      ST_ALL_RED:   if (!w_emg_sync) w_next_state = ST_INIT;
      default:      w_next_state = ST_INIT;
    endcase

    // Registered outputs are decoded from the state being entered.
    unique case (w_next_state)
      ST_NS_GREEN:  w_ns_cmd = LIGHT_GREEN;
      ST_NS_YELLOW: begin
        w_ns_cmd   = LIGHT_YELLOW;
        w_time_sel = TIME_SEL_YELLOW;
      end
      ST_EW_GREEN:  w_ew_cmd = LIGHT_GREEN;
      ST_EW_YELLOW: begin
        w_ew_cmd   = LIGHT_YELLOW;
        w_time_sel = TIME_SEL_YELLOW;
      end
      ST_ALL_RED:   w_emg_active = 1'b1;
      default:      w_emg_active = 1'b0;
    endcase

    w_load_enable = (w_next_state != r_state) && is_timed_state(w_next_state);
  end

  assign load_enable      = r_load_enable;
  assign time_sel         = r_time_sel;
  assign ns_light_cmd     = r_ns_cmd;
  assign ew_light_cmd     = r_ew_cmd;
  assign emergency_active = r_emg_active;
  assign state            = 3'(r_state);

endmodule
